// File: rtl/sa_sequencer.sv
// Sequencer for a SIZE x SIZE systolic array: clear, bias load, operand load, MAC,
// optional activation (enabled by macro SA_SEQ_ACT_EN), then a row-major result drain.
module sa_sequencer #(
  parameter int              SIZE   = 8,
  parameter int              DATA_W = 8,
  parameter int              OP_W   = 5,
  parameter logic [OP_W-1:0] MAC_OP = 5'b01001,
  parameter logic [OP_W-1:0] ACT_OP = 5'b01011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              sa_rstn,
  output logic              sa_bias_ready,
  output logic              sa_data_ready,
  output logic              sa_data_req,
  output logic [DATA_W-1:0] sa_data,
  output logic [OP_W-1:0]   sa_op,
  input  logic [DATA_W-1:0] sa_data_o
);

  localparam int CW = $clog2(SIZE*SIZE) + 1;
  localparam logic [CW-1:0] C_BIAS     = CW'(SIZE);
  localparam logic [CW-1:0] C_LOAD     = CW'(2*SIZE);
  localparam logic [CW-1:0] C_RES_LAST = CW'(SIZE*SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_BIAS, S_LOAD, S_MAC, S_ACT, S_DW, S_DO, S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_res;
  logic                r_bias;
  logic                r_data;
  logic                r_req;
  logic                r_sa_rstn;
  logic [DATA_W-1:0]   r_sa_data;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;
  logic                w_done;
  logic [OP_W-1:0]     w_sa_op;
  logic                w_beat;
  logic                w_out_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CLR;
      S_CLR:  w_next = S_BIAS;
      S_BIAS: if (r_cnt == C_BIAS) w_next = S_LOAD;
      S_LOAD: if (r_cnt == C_LOAD) w_next = S_MAC;
      S_MAC: begin
        if (r_cnt == CW'(2)) begin
`ifdef SA_SEQ_ACT_EN
          w_next = S_ACT;
`else
          w_next = S_DW;
`endif
        end
      end
      S_ACT:  if (r_cnt == CW'(2)) w_next = S_DW;
      S_DW:   if (r_cnt == CW'(1)) w_next = S_DO;
      S_DO:   if (out_ready) w_next = (r_res == C_RES_LAST) ? S_FIN : S_DW;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Input is refused while a strobe is out, giving at most one word per two cycles.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_sa_op     = '0;
    case (r_state)
      S_IDLE: w_busy = 1'b0;
      S_BIAS: w_in_ready = (r_cnt < C_BIAS) && !r_bias && !r_data;
      S_LOAD: w_in_ready = (r_cnt < C_LOAD) && !r_bias && !r_data;
      S_MAC:  w_sa_op = (r_cnt < CW'(2)) ? MAC_OP : '0;
      S_ACT:  w_sa_op = (r_cnt < CW'(2)) ? ACT_OP : '0;
      S_DO:   w_out_valid = 1'b1;
      S_FIN:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign w_beat   = in_valid && w_in_ready;
  assign w_out_hs = w_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_res      <= '0;
      r_bias     <= 1'b0;
      r_data     <= 1'b0;
      r_req      <= 1'b0;
      r_sa_rstn  <= 1'b0;
      r_sa_data  <= '0;
      r_out_data <= '0;
    end else begin
      r_bias    <= 1'b0;
      r_data    <= 1'b0;
      r_req     <= 1'b0;
      r_sa_rstn <= (w_next != S_CLR);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_beat || r_state == S_MAC || r_state == S_ACT || r_state == S_DW)
        r_cnt <= r_cnt + CW'(1);
      if (w_beat) begin
        r_sa_data <= in_data;
        r_bias    <= (r_state == S_BIAS);
        r_data    <= (r_state == S_LOAD);
      end
      // Read data is sampled at the end of the second wait cycle.
      if (r_state == S_DW && r_cnt == CW'(1))
        r_out_data <= sa_data_o;
      if (r_state == S_IDLE)
        r_res <= '0;
      else if (w_out_hs) begin
        r_req <= 1'b1;
        r_res <= r_res + CW'(1);
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  assign out_data      = r_out_data;
  assign busy          = w_busy;
  assign done          = w_done;
  assign sa_rstn       = r_sa_rstn;
  assign sa_bias_ready = r_bias;
  assign sa_data_ready = r_data;
  assign sa_data_req   = r_req;
  assign sa_data       = r_sa_data;
  assign sa_op         = w_sa_op;

endmodule

// File: tb/tb_sa_sequencer.sv
// Directed bench for sa_sequencer (SIZE=8): reset values, abort by reset mid-LOAD,
// full run with strobe/opcode/drain checks and back-pressure on the first result.
module tb_sa_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready, out_valid, out_ready;
  logic       busy, done, sa_rstn, sa_bias_ready, sa_data_ready, sa_data_req;
  logic [7:0] in_data, out_data, sa_data, sa_data_o;
  logic [4:0] sa_op;

  logic       mon_clr;
  logic [7:0] arr, idx;
  int total = 0, bad = 0;
  int bias_n, data_n, req_n, res_n, done_n, viol, dat_err, ord_err;
  logic prev_strobe;

  always #5 clk = ~clk;

  sa_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .sa_rstn(sa_rstn),
    .sa_bias_ready(sa_bias_ready), .sa_data_ready(sa_data_ready), .sa_data_req(sa_data_req),
    .sa_data(sa_data), .sa_op(sa_op), .sa_data_o(sa_data_o)
  );

  // Array stand-in: read data starts at 8'h10 and steps on each read strobe.
  always @(posedge clk) begin
    if (mon_clr) begin
      arr <= 8'h10;
      idx <= 8'h00;
    end else begin
      if (sa_data_req) arr <= arr + 8'h01;
      if (in_valid && in_ready) idx <= idx + 8'h01;
    end
  end
  assign sa_data_o = arr;
  assign in_data   = idx;

  always @(negedge clk) begin
    #2;
    if (mon_clr) begin
      bias_n <= 0; data_n <= 0; req_n <= 0; res_n <= 0; done_n <= 0;
      viol <= 0; dat_err <= 0; ord_err <= 0; prev_strobe <= 1'b0;
    end else if (!rst) begin
      if (sa_bias_ready) bias_n <= bias_n + 1;
      if (sa_data_ready) data_n <= data_n + 1;
      if (sa_data_req)   req_n  <= req_n + 1;
      if (done)          done_n <= done_n + 1;
      viol <= viol
            + (((sa_bias_ready || sa_data_ready) && prev_strobe) ? 1 : 0)
            + (((sa_bias_ready || sa_data_ready) && in_ready) ? 1 : 0)
            + ((int'(sa_bias_ready) + int'(sa_data_ready) + int'(sa_data_req) > 1) ? 1 : 0);
      prev_strobe <= sa_bias_ready || sa_data_ready;
      dat_err <= dat_err
               + ((sa_bias_ready && sa_data !== 8'(bias_n)) ? 1 : 0)
               + ((sa_data_ready && sa_data !== 8'(8 + data_n)) ? 1 : 0);
      if (out_valid && out_ready) begin
        if (out_data !== 8'(16 + res_n)) ord_err <= ord_err + 1;
        res_n <= res_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hold_err;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sa_rstn", sa_rstn, 0);
    chk("rst_sa_op", sa_op, 0);
    chk("rst_sa_data", sa_data, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_strobes", {sa_bias_ready, sa_data_ready, sa_data_req}, 0);
    rst = 1'b0; mon_clr = 1'b0;
    #1 chk("rstn_before_edge", sa_rstn, 0);
    @(negedge clk);
    chk("rstn_released", sa_rstn, 1);
    chk("idle_busy", busy, 0);

    // Run 1: aborted by reset while an operand strobe is high.
    in_valid = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("clr_rstn", sa_rstn, 0);
    chk("clr_busy", busy, 1);
    @(negedge clk);
    chk("bias_rstn", sa_rstn, 1);
    chk("bias_first_ready", in_ready, 1);
    for (int i = 0; i < 100 && !sa_data_ready; i++) @(negedge clk);
    chk("load_strobe_seen", sa_data_ready, 1);
    rst = 1'b1;
    #1;
    chk("midrst_strobe", sa_data_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_sa_rstn", sa_rstn, 0);
    chk("midrst_sa_data", sa_data, 0);
    @(negedge clk); rst = 1'b0; mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
    chk("post_rst_idle", busy, 0);

    // Run 2: complete sequence.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && sa_op == 5'd0; i++) @(negedge clk);
    chk("mac_op0", sa_op, 5'b01001);
    @(negedge clk); chk("mac_op1", sa_op, 5'b01001);
    @(negedge clk); chk("mac_nop", sa_op, 5'b00000);
    chk("bias_pulses", bias_n, 8);
    chk("operand_pulses", data_n, 16);
    chk("strobe_rules", viol, 0);
    chk("strobe_data", dat_err, 0);
`ifdef SA_SEQ_ACT_EN
    @(negedge clk); chk("act_op0", sa_op, 5'b01011);
    @(negedge clk); chk("act_op1", sa_op, 5'b01011);
    @(negedge clk); chk("act_nop", sa_op, 5'b00000);
`endif
    @(negedge clk); chk("dw0_valid", out_valid, 0);
    chk("dw0_op", sa_op, 0);
    @(negedge clk); chk("dw1_valid", out_valid, 0);
    @(negedge clk); chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 8'h10);

    hold_err = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'h10) hold_err++;
    end
    chk("hold_stable", hold_err, 0);
    chk("hold_no_req", req_n, 0);
    chk("hold_no_result", res_n, 0);

    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("drain_out_for_start", out_valid, 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("result_count", res_n, 64);
    chk("read_pulses", req_n, 64);
    chk("result_order", ord_err, 0);
    chk("done_pulses", done_n, 1);
    chk("final_strobe_rules", viol, 0);
    repeat (10) @(negedge clk);
    chk("no_restart_busy", busy, 0);
    chk("no_restart_done", done_n, 1);
    chk("no_restart_bias", bias_n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sa_sequencer.md
SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 8: systolic array edge; the array holds SIZE*SIZE partial sums.
REQ-002 SHALL have parameter DATA_W, default 8: word width of the array data path.
REQ-003 SHALL have parameter OP_W, default 5: width of the array op field.
REQ-004 SHALL have parameter MAC_OP, default 5'b01001: MAC opcode (MULH encoding).
REQ-005 SHALL have parameter ACT_OP, default 5'b01011: activation opcode (MULHU encoding).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1: one-cycle run request.
REQ-009 SHALL have ports in_valid / in_ready / in_data, input / output / input, 1/1/DATA_W: operand stream.
REQ-010 SHALL have ports out_valid / out_ready / out_data, output / input / output, 1/1/DATA_W: result stream.
REQ-011 SHALL have ports busy / done, output, 1 each: run in progress; one-cycle completion pulse.
REQ-012 SHALL have ports sa_rstn, sa_bias_ready, sa_data_ready, sa_data_req, output, 1 each: array reset (active-low), bias strobe, operand strobe, read strobe.
REQ-013 SHALL have ports sa_data / sa_op / sa_data_o, output / output / input, DATA_W / OP_W / DATA_W: array write data, opcode, registered read data.

Function
REQ-014 SHALL implement states IDLE, CLR, BIAS, LOAD, MAC, ACT, DRAIN_WAIT, DRAIN_OUT, FIN.
REQ-015 SHALL in IDLE on start go to CLR; start SHALL be ignored in all other states.
REQ-016 SHALL in CLR drive sa_rstn low exactly one cycle, then go to BIAS.
REQ-017 SHALL, in BIAS and LOAD, raise in_ready only in cycles where the active strobe is low and the word count is below target.
REQ-018 SHALL, on each in_valid&in_ready beat, register in_data onto sa_data and assert the phase strobe for exactly one following cycle, then hold it low at least one cycle (max 1 word per 2 cycles).
REQ-019 SHALL accept exactly SIZE words in BIAS (sa_bias_ready, word k is column-k bias) then exactly 2*SIZE words in LOAD (sa_data_ready; SIZE weights then SIZE inputs).
REQ-020 SHALL in MAC drive sa_op=MAC_OP for exactly 2 cycles, then sa_op=0 for 1 cycle.
REQ-021 SHALL in ACT drive sa_op=ACT_OP for exactly 2 cycles, then sa_op=0 for 1 cycle; sa_op SHALL be 0 in every other state.
REQ-022 SHALL in DRAIN_WAIT idle 2 cycles, then capture sa_data_o into out_data and enter DRAIN_OUT with out_valid=1.
REQ-023 SHALL hold out_valid and out_data stable until out_ready; on handshake pulse sa_data_req for one cycle and return to DRAIN_WAIT.
REQ-024 SHALL emit exactly SIZE*SIZE results in row-major order, then enter FIN, pulse done one cycle, return to IDLE.
REQ-025 SHALL keep busy=1 in every state except IDLE.
REQ-026 SHALL count with counters sized $clog2(SIZE*SIZE)+1; no count SHALL wrap within a run.
REQ-027 SHALL never assert more than one of sa_bias_ready, sa_data_ready, sa_data_req in a cycle.

Reset
REQ-028 SHALL on rst, at any time including mid-run, force IDLE, clear all counters, and set busy=0, done=0, in_ready=0, out_valid=0, out_data=0, sa_data=0, sa_op=0, all strobes=0, sa_rstn=0 while rst is high.
REQ-029 SHALL release sa_rstn to 1 on the first clk edge after rst deasserts.

Configuration
REQ-030 SHALL honour macro SA_SEQ_ACT_EN: defined -> ACT phase executes after MAC; undefined -> MAC goes directly to DRAIN_WAIT and ACT_OP is never driven.

Verification
REQ-031 Reset mid-LOAD with sa_data_ready high -> same cycle strobe 0, busy 0; next start runs full sequence.
REQ-032 SIZE=8, start, 24 words streamed with in_valid held 1 -> 8 bias pulses then 16 operand pulses, each 1 cycle with 1-cycle gap, in_ready never high during strobe.
REQ-033 After LOAD -> sa_op=5'b01001 exactly 2 cycles, then 0; with SA_SEQ_ACT_EN, 5'b01011 exactly 2 cycles after 1 NOP cycle.
REQ-034 out_ready tied 0 for 20 cycles at first result -> out_valid stays 1, out_data unchanged, no sa_data_req pulse.
REQ-035 Full run with out_ready=1 -> exactly 64 results, 64 read pulses, one done pulse, busy falls with done.
REQ-036 start asserted during DRAIN_OUT -> ignored; done count stays 1 for the run.
